perf_dump_unit: RTL and testbench
=================================

# perf_dump_unit

Performance-event collector and readout engine: counts per-cycle event pulses in a bank of live counters. On request, snapshots the whole bank and streams the snapshot out one counter per beat over a valid/ready interface. It is the consumer-side counterpart of the per-module perf event hooks: modules raise event bits, and this block makes the counts observable to a host, trace sink or debug bus bridge.

## Interface
- NUM_EVENTS, default 8: number of event inputs and counters (≥2).
- CNT_WIDTH, default 32: width of each counter.
- ID_WIDTH, default $clog2(NUM_EVENTS): derived; width of the counter index.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- event_inc  in  NUM_EVENTS  bit i high: counter i increments by 1 this cycle.
- dump_req  in  1  single-cycle request to snapshot and stream all counters.
- dump_busy  out  1  high while a snapshot is being streamed.
- req_dropped  out  1  one-cycle pulse when dump_req arrives while busy.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts the beat.
- out_id  out  ID_WIDTH  index of the counter in the current beat.
- out_count  out  CNT_WIDTH  snapshot value of counter out_id.
- out_last  out  1  high on the beat with out_id == NUM_EVENTS-1.

## Operation
- Live counters: every cycle, live[i] <= live[i] + event_inc[i].
  - Arithmetic is modulo 2^CNT_WIDTH: all-ones + 1 wraps to 0, with no flag.
  - Counting never stops, including during streaming.
- FSM states: IDLE, SEND.
- IDLE, dump_req=1: at the edge, snap[i] <= live[i] for all i, using the pre-increment register value.
  - The same cycle's event_inc still goes to live.
  - idx <= 0; state -> SEND.
- SEND: out_valid=1, out_id=idx, out_count=snap[idx], out_last=(idx==NUM_EVENTS-1).
  - A handshake is out_valid & out_ready at the edge.
  - On a handshake with idx < NUM_EVENTS-1: idx <= idx+1.
  - On a handshake with out_last: state -> IDLE.
  - Without out_ready: all out_* hold stable. Snapshot values never change while streaming.
- dump_busy = (state == SEND).
- dump_req while in SEND, including the cycle of the final handshake: ignored, and req_dropped pulses high on the next cycle. Requests are not queued.
- Reset, including mid-stream: state IDLE, idx 0, all live and snap 0.
  - Outputs: out_valid 0, out_id 0, out_count 0, out_last 0, dump_busy 0, req_dropped 0.
  - A partially streamed dump is abandoned and never resumed.

## Timing
- dump_req sampled at edge T → out_valid, dump_busy high after T. The first beat (id 0) is presented in cycle T+1.
- With out_ready held high: one beat per cycle. The dump occupies cycles T+1..T+NUM_EVENTS, and dump_busy falls after the edge ending cycle T+NUM_EVENTS.
- The earliest accepted follow-up dump_req is in the first IDLE cycle, T+NUM_EVENTS+1.
- req_dropped is registered: it is high in the cycle after the rejected dump_req.
- out_* are driven from registers or snapshot muxing only. There is no combinational path from out_ready to out_valid.

## Configuration
- PERF_DUMP_CLEAR_EN defined: an accepted dump_req also clears the live counters. At the capture edge, live[i] <= event_inc[i] (0 or 1), so every counter reports the delta since the previous dump.
- PERF_DUMP_CLEAR_EN undefined: live counters are unaffected by dumps and report cumulative counts since reset.

## Test plan
- Reset, then event_inc[0]=1 for 5 cycles and event_inc[3]=1 for 2 cycles; dump_req with out_ready=1 → 8 consecutive beats, ids 0..7, counts 5,0,0,2,0,0,0,0. out_last is set only on id 7.
- Backpressure: out_ready toggled 1,0,0,1… during a dump while event_inc=all-ones → out_id/out_count stable while stalled. Snapshot values are unaffected by concurrent events. dump_busy clears only after the id-7 handshake.
- Overlapping requests: dump_req during beat 3, and dump_req in the cycle of the id-7 handshake → req_dropped pulses twice, with no second stream. A dump_req one cycle later is accepted.
- Wrap: CNT_WIDTH=4, pulse event 1 for 17 cycles, then dump → id 1 reports 1.
- Clear mode: with PERF_DUMP_CLEAR_EN, 10 events, dump, 3 more events, dump → id 0 reports 10, then 3. Without the macro: 10, then 13. Also check that event_inc high on the capture cycle counts toward the next dump in clear mode.
- Async reset asserted mid-stream at beat 4 → all outputs 0 immediately. After reset release, a new dump reports all zeros.

Source files
------------

// File: rtl/perf_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : perf_dump_unit
// Brief    : Live performance-event counters with snapshot-and-stream readout
//            over a valid/ready beat interface (one counter per beat).
//            Build option PERF_DUMP_CLEAR_EN: an accepted dump also clears the
//            live counters so each dump reports deltas.
// Revision : 1.0
// ============================================================================
module perf_dump_unit #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int ID_WIDTH   = $clog2(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_inc,
    input  logic                  dump_req,
    output logic                  dump_busy,
    output logic                  req_dropped,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_last
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [ID_WIDTH-1:0] C_LAST_ID = ID_WIDTH'(NUM_EVENTS - 1);

    state_t                 state_q;
    logic [ID_WIDTH-1:0]    idx_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   dropped_q;

    logic [CNT_WIDTH-1:0]   live_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]   live_d [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]   snap_q [NUM_EVENTS];

    logic                   capture;
    logic [ID_WIDTH-1:0]    idx_next;

    assign capture  = (state_q == ST_IDLE) && dump_req;
    assign idx_next = idx_q + ID_WIDTH'(1);

    // Counting continues in every state; clear mode restarts from this cycle's event.
    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            live_d[i] = live_q[i] + CNT_WIDTH'(event_inc[i]);
`ifdef PERF_DUMP_CLEAR_EN
            if (capture) begin
                live_d[i] = CNT_WIDTH'(event_inc[i]);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                live_q[i] <= live_d[i];
                if (capture) begin
                    snap_q[i] <= live_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dump_req) begin
                        state_q <= ST_SEND;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // Requests are never queued, even on the final-beat cycle.
                    if (dump_req) begin
                        dropped_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if (last_q) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            idx_q  <= idx_next;
                            last_q <= (idx_next == C_LAST_ID);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_busy   = (state_q == ST_SEND);
    assign req_dropped = dropped_q;
    assign out_valid   = valid_q;
    assign out_id      = idx_q;
    assign out_last    = last_q;
    assign out_count   = valid_q ? snap_q[idx_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_perf_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_dump_unit
// Brief    : Self-checking bench for perf_dump_unit: directed vector table,
//            corner-case sequences and randomized traffic vs. a queue model.
// Revision : 1.0
// ============================================================================
module tb_perf_dump_unit;

    localparam int N = 8;

`ifdef PERF_DUMP_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   event_inc;
    logic           dump_req;
    logic           out_ready;

    logic           dump_busy, req_dropped, out_valid, out_last;
    logic [2:0]     out_id;
    logic [31:0]    out_count;

    logic           w_dump_busy, w_req_dropped, w_out_valid, w_out_last;
    logic [2:0]     w_out_id;
    logic [3:0]     w_out_count;

    always #5 clk = ~clk;

    perf_dump_unit #(.NUM_EVENTS(N), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .event_inc(event_inc), .dump_req(dump_req),
        .dump_busy(dump_busy), .req_dropped(req_dropped), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_count(out_count), .out_last(out_last)
    );

    perf_dump_unit #(.NUM_EVENTS(N), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .event_inc(event_inc), .dump_req(dump_req),
        .dump_busy(w_dump_busy), .req_dropped(w_req_dropped), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_id(w_out_id), .out_count(w_out_count), .out_last(w_out_last)
    );

    int tests = 0;
    int fails = 0;

    // Model: unbounded event totals; expected beats queued at each accepted dump.
    typedef struct {
        int              id;
        longint unsigned cnt;
    } beat_t;

    beat_t           exp_q[$];
    longint unsigned live[N];
    logic            exp_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic busy;
        busy = (exp_q.size() != 0);
        check("valid", 64'(out_valid), 64'(busy));
        check("busy", 64'(dump_busy), 64'(busy));
        check("dropped", 64'(req_dropped), 64'(exp_drop));
        check("w_valid", 64'(w_out_valid), 64'(busy));
        check("w_dropped", 64'(w_req_dropped), 64'(exp_drop));
        if (busy) begin
            check("id", 64'(out_id), 64'(exp_q[0].id));
            check("count", 64'(out_count), exp_q[0].cnt & 64'hFFFF_FFFF);
            check("last", 64'(out_last), 64'(exp_q[0].id == N - 1));
            check("w_id", 64'(w_out_id), 64'(exp_q[0].id));
            check("w_count", 64'(w_out_count), exp_q[0].cnt & 64'hF);
            check("w_last", 64'(w_out_last), 64'(exp_q[0].id == N - 1));
        end
    endtask

    task automatic model_edge(input logic [N-1:0] inc, input logic req, input logic rdy);
        logic busy;
        busy = (exp_q.size() != 0);
        exp_drop = req && busy;
        if (busy && rdy) void'(exp_q.pop_front());
        if (req && !busy) begin
            for (int i = 0; i < N; i++) exp_q.push_back('{i, live[i]});
        end
        for (int i = 0; i < N; i++) begin
            if (req && !busy && CLEAR) live[i] = 64'(inc[i]);
            else live[i] = live[i] + 64'(inc[i]);
        end
    endtask

    // Called one time unit after a rising edge; returns one unit after the next.
    task automatic cycle(input logic [N-1:0] inc, input logic req, input logic rdy);
        event_inc = inc;
        dump_req  = req;
        out_ready = rdy;
        check_outputs();
        @(posedge clk);
        model_edge(inc, req, rdy);
        #1;
    endtask

    task automatic drain(input logic [N-1:0] inc);
        for (int k = 0; k < 64 && exp_q.size() != 0; k++) cycle(inc, 1'b0, 1'b1);
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_now();
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_id", 64'(out_id), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(dump_busy), 64'd0);
        check("rst_dropped", 64'(req_dropped), 64'd0);
        check("rst_w_valid", 64'(w_out_valid), 64'd0);
        check("rst_w_count", 64'(w_out_count), 64'd0);
        exp_q.delete();
        for (int i = 0; i < N; i++) live[i] = 0;
        exp_drop = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] inc;
        logic         req;
        logic         ev;
        logic [2:0]   eid;
        logic [31:0]  ecnt;
        logic         elast;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        event_inc = '0;
        dump_req = 1'b0;
        out_ready = 1'b0;
        exp_drop = 1'b0;
        for (int i = 0; i < N; i++) live[i] = 0;

        for (int k = 0; k < 15; k++) tbl[k] = '{inc: '0, req: 1'b0, ev: 1'b0, eid: '0, ecnt: '0, elast: 1'b0};
        tbl[0].inc = 8'h09; tbl[1].inc = 8'h09;
        tbl[2].inc = 8'h01; tbl[3].inc = 8'h01; tbl[4].inc = 8'h01;
        tbl[5].req = 1'b1;
        for (int k = 6; k < 14; k++) begin
            tbl[k].ev    = 1'b1;
            tbl[k].eid   = 3'(k - 6);
            tbl[k].elast = (k == 13);
        end
        tbl[6].ecnt = 32'd5;
        tbl[9].ecnt = 32'd2;

        #16;
        reset_now();

        // Directed basic dump from the vector table.
        for (int k = 0; k < 15; k++) begin
            check("tbl_valid", 64'(out_valid), 64'(tbl[k].ev));
            if (tbl[k].ev) begin
                check("tbl_id", 64'(out_id), 64'(tbl[k].eid));
                check("tbl_count", 64'(out_count), 64'(tbl[k].ecnt));
                check("tbl_last", 64'(out_last), 64'(tbl[k].elast));
            end
            cycle(tbl[k].inc, tbl[k].req, 1'b1);
        end

        // Backpressure with every event firing.
        cycle('1, 1'b1, 1'b1);
        for (int k = 0; k < 64 && exp_q.size() != 0; k++)
            cycle('1, 1'b0, (k % 4 == 0) || (k % 4 == 3));
        check("bp_done", 64'(exp_q.size()), 64'd0);
        cycle('0, 1'b0, 1'b1);

        // Requests during beat 3 and on the final handshake are dropped.
        cycle('0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle('0, 1'b0, 1'b1);
        check("ovl_beat3", 64'(out_id), 64'd3);
        cycle('0, 1'b1, 1'b1);
        check("ovl_drop1", 64'(req_dropped), 64'd1);
        for (int k = 0; k < 3; k++) cycle('0, 1'b0, 1'b1);
        check("ovl_beat7", 64'(out_last), 64'd1);
        cycle('0, 1'b1, 1'b1);
        check("ovl_drop2", 64'(req_dropped), 64'd1);
        check("ovl_idle", 64'(out_valid), 64'd0);
        cycle('0, 1'b1, 1'b1);
        check("ovl_accept", 64'(dump_busy), 64'd1);
        drain('0);

        // Wrap on the 4-bit instance.
        reset_now();
        for (int k = 0; k < 17; k++) cycle(8'h02, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b0, 1'b1);
        check("wrap_id", 64'(w_out_id), 64'd1);
        check("wrap_count", 64'(w_out_count), 64'd1);
        drain('0);

        // Cumulative vs clear mode, including an event on the capture cycle.
        reset_now();
        for (int k = 0; k < 10; k++) cycle(8'h01, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b1);
        check("clr_first", 64'(out_count), 64'd10);
        drain('0);
        for (int k = 0; k < 3; k++) cycle(8'h01, 1'b0, 1'b1);
        cycle(8'h01, 1'b1, 1'b1);
        check("clr_second", 64'(out_count), CLEAR ? 64'd3 : 64'd13);
        drain('0);
        cycle('0, 1'b1, 1'b1);
        check("clr_third", 64'(out_count), CLEAR ? 64'd1 : 64'd14);
        drain('0);

        // Asynchronous reset at beat 4, then an all-zero dump.
        for (int k = 0; k < 6; k++) cycle(8'h5A, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) cycle('0, 1'b0, 1'b1);
        check("mid_beat4", 64'(out_id), 64'd4);
        reset_now();
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) begin
            check("zero_dump", 64'(out_count), 64'd0);
            cycle('0, 1'b0, 1'b1);
        end
        check("zero_done", 64'(out_valid), 64'd0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++)
            cycle(N'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        drain('0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
